fetch_queue: RTL and testbench

Parametrised successor to the single-entry fetcher: a decoupled instruction prefetch unit with a DEPTH-entry reservation queue between instruction memory and the decoder. It issues sequential fetch requests ahead of decode, tolerates variable-latency in-order memory responses, and supports a front-end redirect (branch/jump/trap) that flushes queued and in-flight fetches. It sits between the PC/redirect logic and the decoder, and sustains one instruction per cycle when memory latency is at most DEPTH-1.

---
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction prefetch unit.
//
// The unit issues sequential fetch requests ahead of the decoder and reserves
// one queue slot per accepted request. In-order memory responses fill the
// reserved slots, and the decoder pops filled entries from the head. A redirect
// flushes the queue and restarts fetch at a new PC. Responses to requests that
// were in flight at the redirect are counted in `squash` and discarded when
// they arrive. Those responses still hold credit until they drain.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   redirect          flush the queue and restart fetch at redirect_pc
//   redirect_pc       new fetch address (4-byte aligned)
//   imem_req_valid    fetch request valid
//   imem_req_ready    memory accepts the request
//   imem_addr         fetch address
//   imem_resp_valid   in-order response valid, one per accepted request
//   imem_data         response instruction word
//   decoder_ready     decoder accepts the head entry
//   fetcher_valid     head entry valid
//   out_instr         head instruction
//   out_pc            head PC
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_data,
  input  logic        decoder_ready,
  output logic        fetcher_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [PW-1:0]    alloc_ptr;
  logic [PW-1:0]    fill_ptr;
  logic [PW-1:0]    head_ptr;
  logic [CW-1:0]    occupancy;
  logic [CW-1:0]    squash;
  // Requests accepted since the last flush and still waiting for a response.
  // This count becomes the squash count when a redirect arrives.
  logic [CW-1:0]    pending;

  logic [CW:0] in_use;
  logic        req_fire;
  logic        pop;
  logic        resp_live;
  logic        resp_drop;

  // Squashed responses still hold credit, so they count against the depth.
  assign in_use = {1'b0, occupancy} + {1'b0, squash};

  assign imem_req_valid = !reset && !redirect && (in_use < DEPTH_C);
  assign imem_addr      = reset ? RESET_PC : fetch_pc;

  // Stale filled bits from earlier laps do not matter when occupancy is zero.
  assign fetcher_valid = !reset && !redirect && filled[head_ptr] && (occupancy != '0);
  assign out_instr     = reset ? '0 : instr_q[head_ptr];
  assign out_pc        = reset ? '0 : pc_q[head_ptr];

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign pop       = fetcher_valid && decoder_ready;
  assign resp_drop = imem_resp_valid && (squash != '0);
  assign resp_live = imem_resp_valid && (squash == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      occupancy <= '0;
      squash    <= '0;
      pending   <= '0;
      filled    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (redirect) begin
      fetch_pc  <= redirect_pc;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      occupancy <= '0;
      filled    <= '0;
      pending   <= '0;
      // Everything still in flight becomes squashed. A response arriving in
      // this cycle retires one of them, whether it was already squashed or not.
      squash    <= squash + pending - CW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        pc_q[alloc_ptr]   <= fetch_pc;
        filled[alloc_ptr] <= 1'b0;
        alloc_ptr         <= alloc_ptr + 1'b1;
        fetch_pc          <= fetch_pc + 32'd4;
      end
      if (resp_drop) begin
        squash <= squash - 1'b1;
      end
      // fill_ptr always points at a slot reserved in an earlier cycle, so this
      // write can never collide with the allocation above.
      if (resp_live) begin
        instr_q[fill_ptr] <= imem_data;
        filled[fill_ptr]  <= 1'b1;
        fill_ptr          <= fill_ptr + 1'b1;
      end
      if (pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      occupancy <= occupancy + CW'(req_fire) - CW'(pop);
      pending   <= pending + CW'(req_fire) - CW'(resp_live);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized scoreboard bench for fetch_queue.
//
// The driver acts as an in-order, variable-latency memory. It tracks the
// expected fetch PC stream and pushes one {pc, word} expectation for every
// accepted request. A redirect or reset discards all expectations and marks
// the memory's in-flight requests as stale. An independent monitor pops one
// expectation for each decoder handshake and compares it with the head entry.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_data = '0;
  logic        decoder_ready = 1'b0;
  logic        fetcher_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_data(imem_data), .decoder_ready(decoder_ready),
    .fetcher_valid(fetcher_valid), .out_instr(out_instr), .out_pc(out_pc)
  );

  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  typedef struct {logic [31:0] addr; int due; int epoch;} mreq_t;

  exp_t  exp_q[$];
  mreq_t mem_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, pops = 0, accepts = 0, epoch = 0;
  int k_min = 1, k_max = 1, ready_pct = 100, dec_pct = 100, resp_pct = 100;
  logic [31:0] model_pc = RPC;
  logic        last_fire = 1'b0;
  logic        last_req_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int stale_count();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // One clock cycle: drive inputs, sample at the falling edge, update the model.
  task automatic cycle(input logic redir, input logic [31:0] rpc);
    int stale;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    decoder_ready  = ($urandom_range(99) < dec_pct);
    redirect       = redir;
    redirect_pc    = rpc;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc && $urandom_range(99) < resp_pct) begin
      imem_resp_valid = 1'b1;
      imem_data       = mem_word(mem_q[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_data       = $urandom();
    end
    @(negedge clk);
    last_req_valid = imem_req_valid;
    last_fire      = 1'b0;
    if (imem_resp_valid) assert (mem_q.size() != 0) else $error("response with nothing outstanding");
    if (reset) begin
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_fetcher_valid", 32'(fetcher_valid), 32'd0);
      check("rst_imem_addr", imem_addr, RPC);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      if (imem_resp_valid) void'(mem_q.pop_front());
    end else begin
      stale = stale_count();
      if (imem_resp_valid) void'(mem_q.pop_front());
      if (redir) begin
        check("redir_req_valid", 32'(imem_req_valid), 32'd0);
        exp_q.delete();
        epoch++;
        model_pc = rpc;
      end else if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_addr, model_pc);
        exp_q.push_back('{model_pc, mem_word(model_pc)});
        mem_q.push_back('{model_pc, cyc + int'($urandom_range(k_max, k_min)), epoch});
        check("credit", 32'((exp_q.size() + stale) <= DEPTH), 32'd1);
        model_pc += 32'd4;
        accepts++;
        last_fire = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle(1'b0, 32'd0);
    reset = 1'b0;
    mem_q.delete();
    exp_q.delete();
    epoch++;
    model_pc = RPC;
  endtask

  // Monitor: compare the head entry against the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (reset === 1'b0) begin
      if (redirect) begin
        check("redir_fetcher_valid", 32'(fetcher_valid), 32'd0);
      end else if (fetcher_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got pc %h, expected no valid entry (cycle %0d)", out_pc, cyc);
        end else begin
          check("out_pc", out_pc, exp_q[0].pc);
          check("out_instr", out_instr, exp_q[0].instr);
          if (decoder_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && redirect) assert (redirect_pc[1:0] == 2'b00) else $error("misaligned redirect_pc");
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, a0;
    @(posedge clk);
    #1;
    do_reset(3);

    // Single-cycle memory, decoder always ready: one instruction per cycle.
    p0 = pops;
    repeat (20) cycle(1'b0, 32'd0);
    check("full_rate_pops", 32'(pops - p0), 32'd18);

    // Decoder stalled: queue fills to DEPTH, then drains in order.
    do_reset(2);
    dec_pct = 0;
    a0 = accepts;
    repeat (10) cycle(1'b0, 32'd0);
    check("bp_accepts", 32'(accepts - a0), 32'(DEPTH));
    check("bp_req_valid_low", 32'(last_req_valid), 32'd0);
    dec_pct = 100;
    p0 = pops;
    repeat (8) cycle(1'b0, 32'd0);
    check("bp_drained", 32'((pops - p0) >= DEPTH), 32'd1);

    // Redirect with one entry filled and three requests in flight.
    do_reset(2);
    dec_pct = 0;
    cycle(1'b0, 32'd0);
    cycle(1'b0, 32'd0);
    resp_pct = 0;
    cycle(1'b0, 32'd0);
    cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h0000_2000);
    resp_pct = 100;
    dec_pct = 100;
    cycle(1'b0, 32'd0);
    check("redir_restart_fire", 32'(last_fire), 32'd1);
    p0 = pops;
    repeat (15) cycle(1'b0, 32'd0);
    check("redir_outputs", 32'((pops - p0) > 0), 32'd1);

    // Redirect colliding with a response and a ready decoder.
    do_reset(2);
    k_min = 2; k_max = 2;
    repeat (6) cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h0000_3000);
    p0 = pops;
    repeat (12) cycle(1'b0, 32'd0);
    check("redir2_outputs", 32'((pops - p0) > 0), 32'd1);

    // Randomized latency, stalls and redirects.
    k_min = 1; k_max = 5; ready_pct = 70; dec_pct = 70;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) < 3) cycle(1'b1, $urandom() & 32'hFFFF_FFFC);
      else cycle(1'b0, 32'd0);
    end

    // Reset mid-stream while responses keep arriving.
    do_reset(6);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 3) cycle(1'b1, $urandom() & 32'hFFFF_FFFC);
      else cycle(1'b0, 32'd0);
    end

    // Stop requesting and let everything outstanding drain.
    ready_pct = 0; dec_pct = 100;
    repeat (40) cycle(1'b0, 32'd0);
    check("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    check("drain_mem_empty", 32'(mem_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
